// File: rtl/candy_match_scanner.sv
// candy_match_scanner: scans the 8x8 board for 3+ runs of one colour,
// then replays every matched cell as a randFlag strobe for refilling.
module candy_match_scanner (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Start,
    input  logic [2:0] ColorXY,
    output logic [2:0] X,
    output logic [2:0] Y,
    output logic       Busy,
    output logic       Done,
    output logic       MatchFound,
    output logic [6:0] MatchCount,
    output logic [2:0] rewriteX,
    output logic [2:0] rewriteY,
    output logic       randFlag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN_H,
        S_SCAN_V,
        S_EMIT,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [2:0]  x_q;
    logic [2:0]  y_q;
    logic [5:0]  k_q;
    logic [1:0]  run_q;
    logic [1:0]  run_d;
    logic [2:0]  prev_q;
    logic [63:0] mark_q;
    logic [63:0] mark_d;
    logic [6:0]  cnt_q;
    logic [6:0]  cnt_d;
    logic        found_q;
    logic        busy_q;
    logic        done_q;
    logic        flag_q;
    logic [2:0]  rwx_q;
    logic [2:0]  rwy_q;

    logic        scan_h;
    logic        scanning;
    logic        first;
    logic        empty;
    logic        hit;
    logic [5:0]  idx;
    logic [5:0]  step;
    logic [5:0]  i1;
    logic [5:0]  i2;
    logic [63:0] mask;
    logic [6:0]  add;

    assign scan_h   = (state_q == S_SCAN_H);
    assign scanning = scan_h || (state_q == S_SCAN_V);
    // Cell index is 8*Y+X in both scan orders; only the neighbour stride differs.
    assign idx      = {y_q, x_q};
    assign step     = scan_h ? 6'd1 : 6'd8;
    assign i1       = idx - step;
    assign i2       = idx - {step[4:0], 1'b0};
    assign first    = scan_h ? (x_q == 3'd0) : (y_q == 3'd0);
    assign empty    = ColorXY[2] & ColorXY[1];

    // Run length of the current line, saturating at 3; empties break runs.
    always_comb begin
        run_d = 2'd1;
        if (!(first || empty || (ColorXY != prev_q))) begin
            run_d = (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
        end
    end

    assign hit = scanning && !empty && (run_d == 2'd3);

    // Marks for this cell and the two behind it; count only newly set bits
    // so a cell shared by a row match and a column match counts once.
    always_comb begin
        mask = '0;
        add  = '0;
        if (hit) begin
            mask[idx] = 1'b1;
            mask[i1]  = 1'b1;
            mask[i2]  = 1'b1;
            add = {6'd0, ~mark_q[idx]}
                + {6'd0, ~mark_q[i1]}
                + {6'd0, ~mark_q[i2]};
        end
        mark_d = mark_q | mask;
        cnt_d  = cnt_q + add;
    end

    // Main FSM: address sequencing, bitmap update, emission and status.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            run_q   <= '0;
            prev_q  <= '0;
            mark_q  <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flag_q  <= 1'b0;
            rwx_q   <= '0;
            rwy_q   <= '0;
        end else if (Enable) begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    flag_q <= 1'b0;
                    if (Start) begin
                        mark_q  <= '0;
                        cnt_q   <= '0;
                        found_q <= 1'b0;
                        x_q     <= '0;
                        y_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN_H;
                    end
                end
                S_SCAN_H: begin
                    run_q  <= run_d;
                    prev_q <= ColorXY;
                    mark_q <= mark_d;
                    cnt_q  <= cnt_d;
                    x_q    <= x_q + 3'd1;
                    if (x_q == 3'd7) begin
                        y_q <= y_q + 3'd1;
                        if (y_q == 3'd7) begin
                            state_q <= S_SCAN_V;
                        end
                    end
                end
                S_SCAN_V: begin
                    run_q  <= run_d;
                    prev_q <= ColorXY;
                    mark_q <= mark_d;
                    cnt_q  <= cnt_d;
                    y_q    <= y_q + 3'd1;
                    if (y_q == 3'd7) begin
                        x_q <= x_q + 3'd1;
                        if (x_q == 3'd7) begin
                            k_q     <= '0;
                            state_q <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    flag_q <= mark_q[k_q];
                    rwx_q  <= k_q[2:0];
                    rwy_q  <= k_q[5:3];
                    k_q    <= k_q + 6'd1;
                    if (k_q == 6'd63) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    flag_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    found_q <= (cnt_q != 7'd0);
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign X          = x_q;
    assign Y          = y_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign MatchFound = found_q;
    assign MatchCount = cnt_q;
    assign rewriteX   = rwx_q;
    assign rewriteY   = rwy_q;
    assign randFlag   = flag_q;

endmodule
